// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128/192/256 key schedule, one 32-bit word per clock
// Optional macro AES_KEYEXP_LAST_KEY_EN adds last_key holding the final round key.

module aes_sub_word (
  input  logic [31:0] a,
  output logic [31:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  end
endmodule

module aes_rcon (
  input  logic [3:0] idx,
  output logic [7:0] rc
);
  always_comb begin
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end
endmodule

module aes_key_expand_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done,
  output logic         err
`ifdef AES_KEYEXP_LAST_KEY_EN
  ,
  output logic [127:0] last_key
`endif
);
  localparam int NK_MAX = MAX_KEY_BITS / 32;
  localparam int TAP6 = (NK_MAX >= 6) ? 5 : NK_MAX - 1;
  localparam int TAP8 = (NK_MAX >= 8) ? 7 : NK_MAX - 1;
  localparam logic [9:0] MAX_BITS = 10'(MAX_KEY_BITS);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [1:0]   mode_q;
  logic [255:0] key_sh;
  logic [31:0]  hist [NK_MAX];
  logic [5:0]   word_cnt;
  logic [2:0]   wrap_cnt;
  logic [3:0]   rcon_idx;
  logic [95:0]  grp_buf;

  logic [3:0]  nk;
  logic [5:0]  last_word;
  logic        mode_ok, stall, advance, hs, in_key, group_done, final_word;
  logic [31:0] prev, tap, sub_in, sub_out, t_word, w_new;
  logic [7:0]  rc;

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    logic [3:0] n;
    case (m)
      2'd0:    n = 4'd4;
      2'd1:    n = 4'd6;
      2'd2:    n = 4'd8;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  aes_sub_word u_sub (.a(sub_in), .y(sub_out));
  aes_rcon     u_rcon (.idx(rcon_idx), .rc(rc));

  assign mode_ok    = (mode != 2'd3) && ({1'b0, nk_of(mode), 5'd0} <= MAX_BITS);
  assign stall      = rk_valid & ~rk_ready;
  assign hs         = rk_valid & rk_ready;
  assign advance    = (state == GEN) & ~stall;
  assign prev       = hist[0];
  assign in_key     = word_cnt < {2'b00, nk};
  assign sub_in     = (wrap_cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign w_new      = in_key ? key_sh[255:224] : (tap ^ t_word);
  assign group_done = advance && (word_cnt[1:0] == 2'd3);
  assign final_word = advance && (word_cnt == last_word);

  // w[i-Nk] sits at history tap Nk-1.
  always_comb begin
    nk = nk_of(mode_q);
    case (mode_q)
      2'd0:    begin last_word = 6'd43; tap = hist[3];    end
      2'd1:    begin last_word = 6'd51; tap = hist[TAP6]; end
      default: begin last_word = 6'd59; tap = hist[TAP8]; end
    endcase
  end

  always_comb begin
    t_word = prev;
    if (wrap_cnt == 3'd0) t_word = sub_out ^ {rc, 24'h000000};
    else if (mode_q == 2'd2 && wrap_cnt == 3'd4) t_word = sub_out;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && mode_ok) state_nxt = GEN;
      end
      GEN:     if (final_word) state_nxt = DRAIN;
      DRAIN:   if (hs && rk_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= 2'd0;
      key_sh   <= '0;
      word_cnt <= '0;
      wrap_cnt <= '0;
      rcon_idx <= '0;
      grp_buf  <= '0;
      for (int k = 0; k < NK_MAX; k++) hist[k] <= '0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef AES_KEYEXP_LAST_KEY_EN
      last_key <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && start) begin
        if (mode_ok) begin
          mode_q   <= mode;
          key_sh   <= key_in;
          word_cnt <= '0;
          wrap_cnt <= '0;
          rcon_idx <= 4'd1;
        end else begin
          err <= 1'b1;
        end
      end
      if (advance) begin
        key_sh  <= {key_sh[223:0], 32'h0};
        hist[0] <= w_new;
        for (int k = 1; k < NK_MAX; k++) hist[k] <= hist[k-1];
        grp_buf  <= {grp_buf[63:0], w_new};
        word_cnt <= word_cnt + 6'd1;
        wrap_cnt <= ({1'b0, wrap_cnt} == nk - 4'd1) ? 3'd0 : wrap_cnt + 3'd1;
        if (!in_key && wrap_cnt == 3'd0) rcon_idx <= rcon_idx + 4'd1;
      end
      // A freshly completed group keeps rk_valid high even on a handshake cycle.
      if (group_done) begin
        rk_out   <= {grp_buf, w_new};
        rk_idx   <= word_cnt[5:2];
        rk_last  <= final_word;
        rk_valid <= 1'b1;
      end else if (hs) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end
      if (hs && rk_last) begin
        done <= 1'b1;
`ifdef AES_KEYEXP_LAST_KEY_EN
        last_key <= rk_out;
`endif
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - scoreboard bench for aes_key_expand_seq against a FIPS-197 style model

module tb_aes_key_expand_seq;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ready;
  logic [1:0]   mode = 2'd0;
  logic [255:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         done;
  logic         err;
`ifdef AES_KEYEXP_LAST_KEY_EN
  logic [127:0] last_key;
`endif

  aes_key_expand_seq dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .mode(mode), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_last(rk_last), .done(done), .err(err)
`ifdef AES_KEYEXP_LAST_KEY_EN
    , .last_key(last_key)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           fails = 0;
  int           cyc = 0;
  int           t0 = 0;
  int           bp_mode = 0;
  int           n_keys = 0;
  int           done_total = 0;
  int           err_total = 0;
  logic [127:0] got [16];
  logic [127:0] saved128 [11];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_flat[2047 - 8*int'(x[8*b +: 8]) -: 8];
    return r;
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < j; k++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    return r;
  endfunction

  // Reference schedule computed directly from the key-expansion recurrence.
  task automatic push_expected(input int m, input logic [255:0] k);
    int          nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    exp_t        e;
    nk = 4 + 2*m;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.key  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx  = 4'(r);
      e.last = (r == nr);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
    return k;
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [255:0] k);
    @(posedge clk); #1;
    start  = 1'b1;
    mode   = m;
    key_in = k;
    t0     = cyc;
    if (m != 2'd3) push_expected(int'(m), k);
    @(posedge clk); #1;
    start  = 1'b0;
    mode   = 2'($urandom);
    key_in = rand_key();
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    lat = -1;
    while (n < 3000) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
      n++;
    end
    vectors++;
    if (lat < 0) begin
      fails++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
    @(negedge clk);
    chk("done_single_pulse", done, 1'b0);
    chk("ready_after_done", ready, 1'b1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_hs_idx(input int idx);
    int n = 0;
    while (n < 3000 && !(rk_valid && rk_ready && rk_idx == 4'(idx))) begin
      @(negedge clk);
      n++;
    end
    chk("hs_seen", n < 3000, 1'b1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk); #2;
      case (bp_mode)
        1:       rk_ready = ($urandom_range(0, 3) != 0);
        2:       rk_ready = 1'b0;
        default: rk_ready = 1'b1;
      endcase
    end
  end

  // Monitor: every handshake pops one expected round key.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done) done_total++;
        if (err) err_total++;
        if (rk_valid && rk_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_rk: got idx %0d key %h expected none", rk_idx, rk_out);
          end else begin
            e = exp_q.pop_front();
            if (rk_out !== e.key || rk_idx !== e.idx || rk_last !== e.last) begin
              fails++;
              $display("FAIL rk: got idx %0d last %0b key %h expected idx %0d last %0b key %h",
                       rk_idx, rk_last, rk_out, e.idx, e.last, e.key);
            end
          end
          got[rk_idx] = rk_out;
          n_keys++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, lat, base_k, base_d, base_e, bad;
    logic [127:0] held;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_rk_valid", rk_valid, 1'b0);
    chk("reset_rk_out", rk_out, 128'h0);
    chk("reset_rk_idx", rk_idx, 4'h0);
    chk("reset_flags", {rk_last, done, err}, 3'b000);
    @(posedge clk); #1 reset = 1'b0;

    base_k = n_keys; base_d = done_total;
    do_start(2'd0, K128);
    wait_done(lat0);
    chk("kat128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("kat128_count", n_keys - base_k, 11);
    chk("kat128_done_once", done_total - base_d, 1);
    chk("kat128_latency", 256'(lat0), 256'(46));
`ifdef AES_KEYEXP_LAST_KEY_EN
    chk("kat128_last_key", last_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
    for (int r = 0; r < 11; r++) saved128[r] = got[r];

    do_start(2'd0, K128);
    wait_hs_idx(2);
    @(posedge clk); #1 bp_mode = 2;
    bad = 0;
    while (!rk_valid && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    held = rk_out;
    for (int s = 0; s < 7; s++) begin
      if (s > 0) begin
        @(negedge clk);
        chk("stall_rk_out", rk_out, held);
      end
      chk("stall_rk_valid", rk_valid, 1'b1);
      chk("stall_rk_idx", rk_idx, 4'd3);
    end
    chk("stall_held_key", held, saved128[3]);
    @(posedge clk); #1 bp_mode = 0;
    wait_done(lat1);
    chk("stall_latency", 256'(lat1), 256'(lat0 + 7));
    for (int r = 0; r < 11; r++) chk("stall_same_seq", got[r], saved128[r]);

    do_start(2'd1, K192);
    wait_done(lat);
    chk("kat192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("kat192_latency", 256'(lat), 256'(54));

    base_e = err_total;
    do_start(2'd3, rand_key());
    @(negedge clk);
    chk("illegal_err", err, 1'b1);
    chk("illegal_ready", ready, 1'b1);
    @(negedge clk);
    chk("illegal_err_pulse", err, 1'b0);
    chk("illegal_no_rk", rk_valid, 1'b0);
    chk("illegal_err_count", err_total - base_e, 1);

    do_start(2'd0, rand_key());
    wait_hs_idx(4);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready", ready, 1'b1);
    chk("midreset_rk_valid", rk_valid, 1'b0);
    chk("midreset_rk_out", rk_out, 128'h0);
    chk("midreset_rk_idx", rk_idx, 4'h0);
    chk("midreset_flags", {rk_last, done, err}, 3'b000);
`ifdef AES_KEYEXP_LAST_KEY_EN
    chk("midreset_last_key", last_key, 128'h0);
`endif
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rk_valid || done) bad++;
    end
    chk("midreset_quiet", bad, 0);

    base_k = n_keys; base_e = err_total;
    do_start(2'd2, K256);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_ready_low", ready, 1'b0);
    start = 1'b1; mode = 2'($urandom_range(0, 3)); key_in = rand_key();
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    chk("kat256_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("kat256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("kat256_count", n_keys - base_k, 15);
    chk("kat256_latency", 256'(lat), 256'(62));
    chk("busy_no_err", err_total - base_e, 0);
`ifdef AES_KEYEXP_LAST_KEY_EN
    chk("kat256_last_key", last_key, 128'hfe4890d1e6188d0b046df344706c631e);
`endif

    for (int run = 0; run < 8; run++) begin
      base_e = err_total;
      bp_mode = 1;
      do_start(2'($urandom_range(0, 2)), rand_key());
      repeat ($urandom_range(3, 30)) @(posedge clk);
      #1;
      start = 1'b1; mode = 2'($urandom_range(0, 3)); key_in = rand_key();
      @(posedge clk); #1 start = 1'b0;
      wait_done(lat);
      bp_mode = 0;
      chk("rand_no_err", err_total - base_e, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
